// File: rtl/weighted_sum_node_if.sv
// Handshake bundle between the tree-walk controller / multiplier and the
// weighted-sum node: product stream in, scored branch decision out.
interface weighted_sum_node_if #(
  parameter int unsigned WIDTH_P   = 15,
  parameter int unsigned WIDTH_ACC = 17
);
  logic                        start;
  logic                        p_valid;
  logic signed [WIDTH_P-1:0]   p;
  logic signed [WIDTH_ACC-1:0] threshold;
  logic                        out_ready;
  logic                        out_valid;
  logic signed [WIDTH_ACC-1:0] sum;
  logic                        decision;
  logic                        busy;
  logic                        drop;

  // Controller / multiplier side
  modport master (
    output start, p_valid, p, threshold, out_ready,
    input  out_valid, sum, decision, busy, drop
  );

  // Node side
  modport slave (
    input  start, p_valid, p, threshold, out_ready,
    output out_valid, sum, decision, busy, drop
  );
endinterface

// File: rtl/weighted_sum_node.sv
// Accumulates N_TERMS signed products into a node score, compares it with the
// node threshold and presents score + branch decision on a valid/ready beat.
module weighted_sum_node #(
  parameter int unsigned WIDTH_P   = 15,
  parameter int unsigned N_TERMS   = 4,
  parameter int unsigned WIDTH_ACC = 17
) (
  input  logic               clk,
  input  logic               reset,
  weighted_sum_node_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(N_TERMS);
  localparam int unsigned EXT_W = WIDTH_ACC - WIDTH_P;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

  // Reject parameter sets that could overflow the accumulator
  if (N_TERMS < 2) begin : g_bad_terms
    $error("weighted_sum_node: N_TERMS must be at least 2");
  end
  if (WIDTH_ACC < WIDTH_P + $clog2(N_TERMS)) begin : g_bad_width
    $error("weighted_sum_node: WIDTH_ACC too narrow for N_TERMS products");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic signed [WIDTH_ACC-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic signed [WIDTH_ACC-1:0] sum_q, sum_d;
  logic                        dec_q, dec_d;
  logic                        out_valid_q, out_valid_d;
  logic                        busy_q;
  logic                        drop_q, drop_d;

  logic signed [WIDTH_ACC-1:0] p_ext;
  logic signed [WIDTH_ACC-1:0] total;

  assign p_ext = {{EXT_W{bus.p[WIDTH_P-1]}}, bus.p};

  // Next-state, accumulate and result capture
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    dec_d       = dec_q;
    out_valid_d = out_valid_q;
    total       = acc_q + p_ext;
    // Products arriving while not accumulating are discarded and flagged
    drop_d      = bus.p_valid && (state_q != S_ACCUM);

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_ACCUM;
        end
      end

      S_ACCUM: begin
        if (bus.p_valid) begin
          if (cnt_q == LAST) begin
            sum_d       = total;
            dec_d       = (total >= bus.threshold);
            out_valid_d = 1'b1;
            state_d     = S_HOLD;
          end else begin
            acc_d = total;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          // A start on the handshake cycle chains straight into the next evaluation
          if (bus.start) begin
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_ACCUM;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      dec_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      dec_q       <= dec_d;
      out_valid_q <= out_valid_d;
      busy_q      <= (state_d != S_IDLE);
      drop_q      <= drop_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.decision  = dec_q;
  assign bus.busy      = busy_q;
  assign bus.drop      = drop_q;

endmodule

// File: tb/tb_weighted_sum_node.sv
// Directed and randomized checks of weighted_sum_node against a per-cycle
// transaction-level model of the evaluation rules.
module tb_weighted_sum_node;

  localparam int unsigned WP = 15;
  localparam int unsigned NT = 4;
  localparam int unsigned WA = 17;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  weighted_sum_node_if #(.WIDTH_P(WP), .WIDTH_ACC(WA)) bus ();

  weighted_sum_node #(
    .WIDTH_P  (WP),
    .N_TERMS  (NT),
    .WIDTH_ACC(WA)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: an evaluation is either collecting products or presenting a result
  bit m_collect = 1'b0;
  bit m_present = 1'b0;
  int m_acc     = 0;
  int m_cnt     = 0;
  int m_sum     = 0;
  bit m_dec     = 1'b0;
  bit m_drop    = 1'b0;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit st, input bit pv,
                            input int pval, input int thr, input bit rdy);
    if (rst) begin
      m_collect = 1'b0;
      m_present = 1'b0;
      m_acc     = 0;
      m_cnt     = 0;
      m_sum     = 0;
      m_dec     = 1'b0;
      m_drop    = 1'b0;
    end else begin
      m_drop = pv && !m_collect;
      if (m_collect) begin
        if (pv) begin
          if (m_cnt == int'(NT) - 1) begin
            m_sum     = m_acc + pval;
            m_dec     = (m_sum >= thr);
            m_collect = 1'b0;
            m_present = 1'b1;
          end else begin
            m_acc = m_acc + pval;
            m_cnt = m_cnt + 1;
          end
        end
      end else if (m_present) begin
        if (rdy) begin
          m_present = 1'b0;
          if (st) begin
            m_collect = 1'b1;
            m_acc     = 0;
            m_cnt     = 0;
          end
        end
      end else if (st) begin
        m_collect = 1'b1;
        m_acc     = 0;
        m_cnt     = 0;
      end
    end
  endtask

  // One clock: drive at negedge, advance, then compare every output with the model
  task automatic cyc(input bit rst, input bit st, input bit pv, input int pval,
                     input int thr, input bit rdy);
    reset         = rst;
    bus.start     = st;
    bus.p_valid   = pv;
    bus.p         = WP'(pval);
    bus.threshold = WA'(thr);
    bus.out_ready = rdy;
    model_step(rst, st, pv, pval, thr, rdy);
    @(posedge clk);
    @(negedge clk);
    chk("m_out_valid", 32'(bus.out_valid), 32'(m_present));
    chk("m_sum",       32'(bus.sum),       m_sum);
    chk("m_decision",  32'(bus.decision),  32'(m_dec));
    chk("m_busy",      32'(bus.busy),      32'(m_collect || m_present));
    chk("m_drop",      32'(bus.drop),      32'(m_drop));
  endtask

  // One evaluation of four products with optional gaps and a stretched HOLD
  task automatic eval4(input bit do_start, input int p0, input int p1, input int p2,
                       input int p3, input int thr, input int max_gap, input int hold,
                       input bit next_start, input int exp_sum, input bit exp_dec,
                       input string tag);
    int ps[4];
    ps = '{p0, p1, p2, p3};
    if (do_start) cyc(1'b0, 1'b1, 1'b0, 0, thr, 1'b0);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, max_gap)) cyc(1'b0, 1'b0, 1'b0, 0, thr, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, ps[i], thr, 1'b0);
    end
    chk({tag, "_ov"},  32'(bus.out_valid), 1);
    chk({tag, "_sum"}, 32'(bus.sum),       exp_sum);
    chk({tag, "_dec"}, 32'(bus.decision),  32'(exp_dec));
    repeat (hold) begin
      cyc(1'b0, 1'b0, 1'b0, 0, thr, 1'b0);
      chk({tag, "_hold_ov"},  32'(bus.out_valid), 1);
      chk({tag, "_hold_sum"}, 32'(bus.sum),       exp_sum);
    end
    cyc(1'b0, next_start, 1'b0, 0, thr, 1'b1);
    chk({tag, "_done_ov"}, 32'(bus.out_valid), 0);
  endtask

  initial begin
    int pval;
    int thr;
    bit rst;
    bit st;
    bit pv;
    bit rdy;

    // Reset state
    cyc(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    chk("rst_ov",   32'(bus.out_valid), 0);
    chk("rst_sum",  32'(bus.sum),       0);
    chk("rst_busy", 32'(bus.busy),      0);
    chk("rst_drop", 32'(bus.drop),      0);

    // Maximum positive products at and just past the threshold
    eval4(1'b1, 15345, 15345, 15345, 15345, 61380, 0, 0, 1'b0, 61380, 1'b1, "max_eq");
    eval4(1'b1, 15345, 15345, 15345, 15345, 61381, 0, 0, 1'b0, 61380, 1'b0, "max_gt");
    chk("idle_busy", 32'(bus.busy), 0);

    // Signed mix with negative thresholds
    eval4(1'b1, -5, 100, -200, 7, -99, 0, 0, 1'b0, -98, 1'b1, "mix_lo");
    eval4(1'b1, -5, 100, -200, 7, -97, 0, 0, 1'b0, -98, 1'b0, "mix_hi");

    // Gapped beats and stalled consumer
    eval4(1'b1, 15345, 15345, 15345, 15345, 61380, 3, 5, 1'b0, 61380, 1'b1, "gap");

    // Back-to-back: start on the handshake cycle skips IDLE
    eval4(1'b1, -5, 100, -200, 7, -99, 1, 2, 1'b1, -98, 1'b1, "b2b_a");
    chk("b2b_busy", 32'(bus.busy), 1);
    eval4(1'b0, 1, 1, 1, 1, 4, 0, 0, 1'b0, 4, 1'b1, "b2b_b");

    // Stray products in IDLE, with start, and in HOLD; start in ACCUM ignored
    cyc(1'b0, 1'b0, 1'b1, 123, 0, 1'b0);
    chk("stray_idle_drop", 32'(bus.drop), 1);
    chk("stray_idle_sum",  32'(bus.sum),  4);
    cyc(1'b0, 1'b1, 1'b1, 999, 100, 1'b0);
    chk("stray_start_drop", 32'(bus.drop), 1);
    cyc(1'b0, 1'b0, 1'b1, 10, 100, 1'b0);
    chk("accum_nodrop", 32'(bus.drop), 0);
    cyc(1'b0, 1'b1, 1'b0, 0, 100, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 20, 100, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 30, 100, 1'b0);
    chk("start_ign_ov", 32'(bus.out_valid), 0);
    cyc(1'b0, 1'b0, 1'b1, 40, 100, 1'b0);
    chk("stray_sum", 32'(bus.sum),      100);
    chk("stray_dec", 32'(bus.decision), 1);
    cyc(1'b0, 1'b0, 1'b1, 555, 100, 1'b0);
    chk("stray_hold_drop", 32'(bus.drop),      1);
    chk("stray_hold_sum",  32'(bus.sum),       100);
    cyc(1'b1 == 1'b0, 1'b1, 1'b0, 0, 100, 1'b0);
    chk("hold_start_ign", 32'(bus.out_valid), 1);
    cyc(1'b0, 1'b0, 1'b0, 0, 100, 1'b1);
    chk("stray_done_busy", 32'(bus.busy), 0);

    // Reset mid-ACCUM discards partial work
    cyc(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 5000, 0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 6000, 0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    chk("midrst_ov",   32'(bus.out_valid), 0);
    chk("midrst_sum",  32'(bus.sum),       0);
    chk("midrst_busy", 32'(bus.busy),      0);
    eval4(1'b1, 3, 4, 5, 6, 18, 0, 0, 1'b0, 18, 1'b1, "post_rst");

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      rst  = ($urandom_range(0, 79) == 0);
      st   = ($urandom_range(0, 3) == 0);
      pv   = ($urandom_range(0, 1) == 1);
      rdy  = ($urandom_range(0, 2) != 0);
      pval = int'($urandom_range(0, 32767)) - 16384;
      if (m_collect && m_cnt == int'(NT) - 1 && $urandom_range(0, 1) == 1) begin
        thr = m_acc + pval + int'($urandom_range(0, 2)) - 1;
        if (thr > 65535)  thr = 65535;
        if (thr < -65536) thr = -65536;
      end else begin
        thr = int'($urandom_range(0, 131071)) - 65536;
      end
      cyc(rst, st, pv, pval, thr, rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/weighted_sum_node.md
Name: weighted_sum_node

Overview:
- Downstream consumer of the feature×weight multiplier stage.
- Accumulates N_TERMS signed products (one per feature, one per valid beat) into a node score.
- Compares the score against a per-node threshold and emits a branch decision plus the score on a valid/ready output handshake.
- Sits between the multiplier and the tree-walk controller. The controller drives start and p_valid aligned to the multiplier's 1-cycle product latency.

Parameters:
- WIDTH_P, 15, product width in bits, signed (feature width 10 + weight width 4 + 1).
- N_TERMS, 4, products accumulated per evaluation; must be ≥ 2.
- WIDTH_ACC, 17, accumulator/sum/threshold width, signed; must be ≥ WIDTH_P + clog2(N_TERMS). Elaboration fails otherwise.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin a new evaluation; accepted only as specified below.
- p_valid  in  1  p carries a product to accumulate this cycle.
- p  in  WIDTH_P  signed product from the multiplier.
- threshold  in  WIDTH_ACC  signed node threshold; sampled on the cycle the last product is accepted.
- out_valid  out  1  sum/decision valid.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH_ACC  signed accumulated score.
- decision  out  1  1 when sum ≥ threshold (signed compare), else 0.
- busy  out  1  high in ACCUM or HOLD.
- drop  out  1  one-cycle pulse when p_valid arrives outside ACCUM.

Behaviour:
- Reset is synchronous, active-high, and has priority over all other inputs.
  - On reset: state=IDLE, acc=0, cnt=0, sum=0, decision=0, out_valid=0, busy=0, drop=0.
  - Reset mid-ACCUM or mid-HOLD discards the partial or held result; no output beat is produced.
- States: IDLE, ACCUM, HOLD.
- IDLE:
  - start=1 → acc=0, cnt=0, go ACCUM.
  - p_valid in the same cycle as start is not accumulated and pulses drop.
- ACCUM:
  - On p_valid=1 and cnt < N_TERMS-1: acc += sign-extend(p), cnt += 1.
  - On p_valid=1 and cnt == N_TERMS-1:
    - sum ← acc + sign-extend(p).
    - decision ← (acc + sign-extend(p)) ≥ threshold, signed, using the full WIDTH_ACC values.
    - out_valid ← 1, go HOLD.
  - p_valid=0 holds all state; gaps between beats are allowed and unbounded.
  - start in ACCUM is ignored.
- HOLD:
  - out_valid=1; sum and decision are stable until handshake.
  - out_ready=1 completes the beat; out_valid falls next cycle.
  - If start=1 in the handshake cycle → go directly to ACCUM (acc=0, cnt=0), giving back-to-back evaluations with no IDLE cycle.
  - Otherwise go IDLE.
  - start without out_ready in HOLD is ignored.
  - p_valid in HOLD is ignored and pulses drop.
- Latency:
  - out_valid rises the cycle after the last product is accepted.
  - Minimum evaluation is N_TERMS+1 cycles from start to out_valid.
- Arithmetic:
  - Products are always sign-extended from WIDTH_P to WIDTH_ACC.
  - With the parameter rule, no overflow is possible; no saturation or wrap logic.
  - Combinations such as p = -1 with a large threshold must compare correctly as signed.
- sum and decision hold their last values in IDLE; only out_valid qualifies them.
- busy is registered and equals (state != IDLE).
- drop is registered; it is high the cycle after the offending p_valid.

Test Plan:
- Reset, start, then 4 beats p=15345 (x=1023, a=15), threshold=61380 → out_valid 1 cycle after 4th beat, sum=61380, decision=1; with threshold=61381 → decision=0.
- Signed mix: p = -5, 100, -200, 7, threshold=-99 → sum=-98, decision=1; threshold=-97 → decision=0.
- Gapped beats with p_valid low 0-3 cycles between beats, out_ready held low 5 cycles → result identical to gapless case; out_valid and sum stable throughout HOLD, beat completes on out_ready.
- Back-to-back: out_ready=1 and start=1 in same HOLD cycle, second set p=1,1,1,1, threshold=4 → second beat sum=4, decision=1, no IDLE cycle between (busy stays 1).
- Stray traffic: p_valid=1 in IDLE and in HOLD → drop pulses each time, acc/cnt/sum unchanged; start during ACCUM → ignored, count continues.
- Reset asserted after 2 of 4 beats → next cycle IDLE, out_valid=0, sum=0; fresh run afterwards produces a correct sum with no residue.
